button_event_fsm: RTL



---
 rtl/button_event_fsm.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/button_event_fsm.sv
// button_event_fsm: turns a debounced, clk-synchronous button level into
// single-cycle UI events (press, release, long-press, auto-repeat,
// double-click) plus a held level. All outputs are registered (latency 1).
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   btn_in    debounced button level, 1 = pressed
//   press_o   one-cycle pulse on each press
//   release_o one-cycle pulse on each release
//   long_o    one-cycle pulse when the hold reaches LONG_CYC
//   repeat_o  one-cycle pulse every REPEAT_CYC while in long-hold
//   dclick_o  one-cycle pulse on the second press of a double-click
//   held_o    level, 1 while in the HOLD state
module button_event_fsm #(
    parameter int unsigned LONG_CYC   = 27_000_000,
    parameter int unsigned REPEAT_CYC = 5_400_000,
    parameter int unsigned DCLICK_CYC = 8_100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic dclick_o,
    output logic held_o
);

    localparam int unsigned MAX_AB  = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > DCLICK_CYC) ? MAX_AB : DCLICK_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYC - 1);
    localparam logic [CW-1:0] DCLICK_TC = CW'(DCLICK_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN1 = 3'd1,
        HOLD  = 3'd2,
        GAP   = 3'd3,
        DOWN2 = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          btn_q;
    logic          rise, fall;
    logic          press_d, release_d, long_d, repeat_d, dclick_d, held_d;

    // Edge detect against the previous-cycle button level.
    assign rise = btn_in & ~btn_q;
    assign fall = ~btn_in & btn_q;

    // State, timer, edge history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_q     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            dclick_o  <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            btn_q     <= btn_in;
            press_o   <= press_d;
            release_o <= release_d;
            long_o    <= long_d;
            repeat_o  <= repeat_d;
            dclick_o  <= dclick_d;
            held_o    <= held_d;
        end
    end

    // Next-state, timer and event decode. Edges take priority over
    // terminal counts in every state.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        dclick_d  = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    press_d = 1'b1;
                    state_d = DOWN1;
                end
            end

            DOWN1, DOWN2: begin
                cnt_d = cnt + CNT_ONE;
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    // Only the first press of a pair opens a double-click window.
                    state_d   = (state == DOWN1) ? GAP : IDLE;
                end else if (cnt == LONG_TC) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                cnt_d = cnt + CNT_ONE;
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt == REPEAT_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end

            GAP: begin
                cnt_d = cnt + CNT_ONE;
                if (rise) begin
                    press_d  = 1'b1;
                    dclick_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = DOWN2;
                end else if (cnt == DCLICK_TC) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        held_d = (state_d == HOLD);
    end

endmodule
